dmem_arbiter: RTL

- Shares the single-port data memory between the pipeline memory stage (CPU port) and two peripheral requesters (P0 = PS/2 key-code writer, P1 = VGA framebuffer fetch engine).
- The CPU port has priority. Peripherals share leftover slots round-robin.
- A per-peripheral wait counter prevents starvation. When it saturates, the CPU is stalled for one cycle.
- Sits between the memory stage / peripheral engines and the dmem instance, which is clocked on ~clock.

---
 rtl/dmem_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between the CPU memory stage and two peripherals.
// CPU has priority; peripherals round-robin, with a wait counter that preempts the CPU when saturated.
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              p0_req,
    input  logic              p0_wren,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    input  logic              p1_req,
    input  logic              p1_wren,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic [1:0]        per_rvalid,
    output logic [DATA_W-1:0] per_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);
    typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_P0, OWN_P1} owner_t;

    localparam logic [7:0] WMAX = 8'(MAX_WAIT);

    logic [7:0] wait_0, wait_1;
    logic       rr_ptr;
    logic       starve_0, starve_1;
    owner_t     owner, tie;

    assign starve_0 = p0_req && (wait_0 == WMAX);
    assign starve_1 = p1_req && (wait_1 == WMAX);
    assign tie      = rr_ptr ? OWN_P1 : OWN_P0;

    always_comb begin
        owner = (starve_0 && starve_1) ? tie :
                starve_0               ? OWN_P0 :
                starve_1               ? OWN_P1 :
                cpu_req                ? OWN_CPU :
                (p0_req && p1_req)     ? tie :
                p0_req                 ? OWN_P0 :
                p1_req                 ? OWN_P1 : OWN_IDLE;
    end

    assign p0_gnt    = (owner == OWN_P0);
    assign p1_gnt    = (owner == OWN_P1);
    assign cpu_stall = cpu_req && (owner != OWN_CPU);
    assign cpu_rdata = mem_q;

    always_comb begin
        mem_wren = (owner == OWN_CPU) ? cpu_wren :
                   (owner == OWN_P0)  ? p0_wren  :
                   (owner == OWN_P1)  ? p1_wren  : 1'b0;
        mem_addr = (owner == OWN_CPU) ? cpu_addr :
                   (owner == OWN_P0)  ? p0_addr  :
                   (owner == OWN_P1)  ? p1_addr  : '0;
        mem_data = (owner == OWN_CPU) ? cpu_wdata :
                   (owner == OWN_P0)  ? p0_wdata  :
                   (owner == OWN_P1)  ? p1_wdata  : '0;
    end

    // dmem is clocked on the falling edge, so mem_q already holds this cycle's read here
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_0     <= '0;
            wait_1     <= '0;
            rr_ptr     <= 1'b0;
            per_rvalid <= '0;
            per_rdata  <= '0;
        end else begin
            wait_0     <= (!p0_req || p0_gnt) ? 8'd0 : (wait_0 == WMAX) ? WMAX : wait_0 + 8'd1;
            wait_1     <= (!p1_req || p1_gnt) ? 8'd0 : (wait_1 == WMAX) ? WMAX : wait_1 + 8'd1;
            rr_ptr     <= p0_gnt ? 1'b1 : p1_gnt ? 1'b0 : rr_ptr;
            per_rvalid <= {p1_gnt && !p1_wren, p0_gnt && !p0_wren};
            per_rdata  <= ((p0_gnt && !p0_wren) || (p1_gnt && !p1_wren)) ? mem_q : per_rdata;
        end
    end
endmodule
